// File: rtl/regarray_phase_ctrl.sv
// Phase sequencer for the register-array/ALU top: decodes one RV32 R-type word per handshake
// and issues rr/f/wb strobes. Optional STEP_MODE_EN adds a `step` input gating each strobe.
module regarray_phase_ctrl #(
  parameter int unsigned PHASE_GAP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef STEP_MODE_EN
  input  logic        step,
`endif
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  R_Addr_A,
  output logic [4:0]  R_Addr_B,
  output logic [4:0]  W_Addr,
  output logic [3:0]  ALU_OP,
  output logic        rr_en,
  output logic        f_en,
  output logic        wb_en,
  output logic        Reg_Write,
  output logic        done,
  output logic        illegal
);

  if (PHASE_GAP > 15) begin : g_gap_range
    $error("PHASE_GAP must be in 0..15");
  end

  localparam logic [3:0] GapLast = 4'((PHASE_GAP == 0) ? 0 : PHASE_GAP - 1);

  typedef enum logic [2:0] {StIdle, StRr, StGap1, StF, StGap2, StWb, StErr} state_e;

  state_e      state_q;
  logic [3:0]  gap_q;
  logic        rr_q, f_q, wb_q, rw_q, illegal_q;
  logic [4:0]  ra_q, rb_q, wa_q;
  logic [3:0]  op_q;
  logic        adv;
  logic        legal;

  // Strobe registers mark the armed phase; adv decides the cycle in which it actually fires.
`ifdef STEP_MODE_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    legal = 1'b0;
    if (instr[6:0] == 7'b0110011) begin
      if (instr[31:25] == 7'b0000000) begin
        legal = 1'b1;
      end else if (instr[31:25] == 7'b0100000 &&
                   (instr[14:12] == 3'b000 || instr[14:12] == 3'b101)) begin
        legal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gap_q     <= 4'd0;
      rr_q      <= 1'b0;
      f_q       <= 1'b0;
      wb_q      <= 1'b0;
      rw_q      <= 1'b0;
      illegal_q <= 1'b0;
      ra_q      <= 5'd0;
      rb_q      <= 5'd0;
      wa_q      <= 5'd0;
      op_q      <= 4'd0;
    end else begin
      rr_q      <= 1'b0;
      f_q       <= 1'b0;
      wb_q      <= 1'b0;
      rw_q      <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            ra_q <= instr[19:15];
            rb_q <= instr[24:20];
            wa_q <= instr[11:7];
            op_q <= {instr[30], instr[14:12]};
            if (legal) begin
              state_q <= StRr;
              rr_q    <= 1'b1;
            end else begin
              state_q   <= StErr;
              illegal_q <= 1'b1;
            end
          end
        end
        StRr: begin
          if (!adv) begin
            rr_q <= 1'b1;
          end else if (PHASE_GAP == 0) begin
            state_q <= StF;
            f_q     <= 1'b1;
          end else begin
            state_q <= StGap1;
            gap_q   <= GapLast;
          end
        end
        StGap1: begin
          if (gap_q == 4'd0) begin
            state_q <= StF;
            f_q     <= 1'b1;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        StF: begin
          if (!adv) begin
            f_q <= 1'b1;
          end else if (PHASE_GAP == 0) begin
            state_q <= StWb;
            wb_q    <= 1'b1;
            rw_q    <= (wa_q != 5'd0);
          end else begin
            state_q <= StGap2;
            gap_q   <= GapLast;
          end
        end
        StGap2: begin
          if (gap_q == 4'd0) begin
            state_q <= StWb;
            wb_q    <= 1'b1;
            rw_q    <= (wa_q != 5'd0);
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        StWb: begin
          if (adv) begin
            state_q <= StIdle;
          end else begin
            wb_q <= 1'b1;
            rw_q <= rw_q;
          end
        end
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instr_ready = (state_q == StIdle) && rst_n;
  assign R_Addr_A    = ra_q;
  assign R_Addr_B    = rb_q;
  assign W_Addr      = wa_q;
  assign ALU_OP      = op_q;
  assign rr_en       = rr_q & adv;
  assign f_en        = f_q & adv;
  assign wb_en       = wb_q & adv;
  assign done        = wb_q & adv;
  assign Reg_Write   = rw_q & adv;
  assign illegal     = illegal_q;

endmodule
